nonce_search_controller: RTL
============================

# nonce_search_controller

Sequencer that sits directly downstream of the SHA-256 computational block and drives it through a nonce range. For each nonce it builds the 447-bit message, pulses the SHA block's new-message and begin-computation inputs, and waits for completion. It then compares the 256-bit digest against a difficulty target. It stops on the first digest strictly below the target, on range exhaustion, on a completion timeout, or on abort.

## Interface
- NONCE_W, 32, nonce width; the nonce occupies the low bits of the message
- MSG_LEN, 64'd447, constant driven on sha_length
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before error
- clk  in  1  system clock; all state changes on rising edge
- n_rst  in  1  reset; synchronous, active-low (sampled on rising clk edge)
- start  in  1  begin search; sampled only in IDLE
- abort  in  1  cancel search; effective in any non-IDLE state
- header_prefix  in  447-NONCE_W  fixed upper message bits; sampled at start
- target  in  256  difficulty target; unsigned; sampled at start
- nonce_start  in  NONCE_W  first nonce tried; sampled at start
- nonce_end  in  NONCE_W  last nonce tried (inclusive); sampled at start
- sha_msg  out  447  {header_reg, nonce_reg}
- sha_length  out  64  constant MSG_LEN
- sha_new_msg  out  1  one-cycle pulse; loads the preprocessor
- sha_begin  out  1  one-cycle pulse; restarts the SHA counters
- sha_complete  in  1  computationComplete from the SHA block
- sha_digest  in  256  SHAoutput from the SHA block
- busy  out  1  high in every state except IDLE/DONE
- found  out  1  sticky; a digest below the target was found
- exhausted  out  1  sticky; nonce_end was tried without success
- timeout_err  out  1  sticky; WAIT exceeded TIMEOUT_CYCLES
- result_nonce  out  NONCE_W  winning nonce; valid when found
- result_hash  out  256  winning digest; valid when found
- attempts  out  NONCE_W+1  number of nonces fully checked in the current or last run

## Operation
- States: IDLE, LOAD, BEGIN, WAIT, CHECK, DONE.
- IDLE: start=1 and abort=0 latches header_prefix, target and nonce_start into nonce_reg, and nonce_end. It clears found, exhausted, timeout_err, attempts, result_nonce and result_hash, then goes to LOAD.
- LOAD: sha_new_msg=1 for this cycle, with sha_msg already stable. Go to BEGIN.
- BEGIN: sha_begin=1 for this cycle. Clear wait_cnt. Go to WAIT.
- WAIT: increment wait_cnt.
  - sha_complete=1: register sha_digest into digest_reg and go to CHECK.
  - Otherwise, wait_cnt==TIMEOUT_CYCLES-1: set timeout_err and go to DONE.
- CHECK: increment attempts.
  - digest_reg < target (strict, unsigned 256-bit): set found, result_nonce=nonce_reg, result_hash=digest_reg, go to DONE.
  - Else nonce_reg==nonce_end: set exhausted, go to DONE.
  - Else nonce_reg = nonce_reg+1 mod 2^NONCE_W, go to LOAD.
- DONE: hold all results. start=1 behaves as in IDLE and begins a new run. abort=1 goes to IDLE.
- Range wrap: nonce_end < nonce_start is legal. The search wraps through all-ones to 0.
  - nonce_start==nonce_end tries exactly one nonce.
  - Full range: start 0, end all-ones gives 2^NONCE_W attempts, which is why attempts is NONCE_W+1 bits wide.
- Digest equal to target is not a success.
- abort in LOAD/BEGIN/WAIT/CHECK: go to IDLE next cycle. No sha_* pulse is issued that cycle. Sticky flags are cleared; attempts keeps its value.
- abort and start both high in IDLE/DONE: abort wins; the block goes to or stays in IDLE.
- start while busy: ignored.
- sha_complete outside WAIT: ignored.

## Timing
- Reset: state=IDLE; all outputs 0, except sha_length=MSG_LEN.
  - sha_msg = {0, 0}.
  - Reset mid-search has the same effect; any SHA computation in flight is ignored.
- Start-to-issue timing: start sampled at edge 0; sha_new_msg high cycle 1; sha_begin high cycle 2; WAIT from cycle 3.
- The SHA block must drop computationComplete within one cycle of sha_begin. The first WAIT cycle samples sha_complete.
- Per-nonce cost is SHA latency L plus 3 cycles: LOAD, BEGIN, CHECK.
- found/exhausted/timeout_err rise the cycle after CHECK or the final WAIT cycle, together with busy falling.
- sha_msg changes only on the LOAD entry edge; it is stable from LOAD through CHECK.

## Test plan
- Bench SHA model returns digest={~nonce,224'h0} after 70 cycles. Stimulus: target={32'hFFFFFFF0,224'h0}, start 0x0C, end 0x20. Required: found=1, result_nonce=0x10, attempts=5, exactly 5 new_msg and 5 begin pulses.
- Same model, target=0, start 0x3, end 0x5. Required: exhausted=1, found=0, attempts=3, last sha_msg low bits=0x5.
- Wrap: start 0xFFFFFFFE, end 0x1, target=0. Required: nonces FFFFFFFE, FFFFFFFF, 0, 1 are issued, then exhausted, with attempts=4.
- Boundary compare: the model returns digest==target. Required: no found, and the search advances; a digest of target-1 sets found.
- Model never asserts complete, TIMEOUT_CYCLES=16. Required: timeout_err rises exactly 16 cycles after the first WAIT cycle, and busy falls.
- Abort during WAIT of the 2nd nonce. Required: IDLE next cycle, no further pulses, flags 0, attempts=1. Also apply n_rst=0 mid-LOAD. Required: all outputs reset on that edge.

Source files
------------

// File: rtl/nonce_search_controller_if.sv
// SHA-side bus of the nonce search controller: message/length out,
// new-message and begin pulses out, completion flag and digest back.
interface nonce_search_controller_if;
    logic [446:0] sha_msg;
    logic [63:0]  sha_length;
    logic         sha_new_msg;
    logic         sha_begin;
    logic         sha_complete;
    logic [255:0] sha_digest;

    // Controller side: drives the message and the control pulses
    modport master (
        output sha_msg,
        output sha_length,
        output sha_new_msg,
        output sha_begin,
        input  sha_complete,
        input  sha_digest
    );

    // SHA block side: consumes the message, reports completion
    modport slave (
        input  sha_msg,
        input  sha_length,
        input  sha_new_msg,
        input  sha_begin,
        output sha_complete,
        output sha_digest
    );
endinterface

// File: rtl/nonce_search_controller.sv
// Nonce search sequencer. Walks the SHA-256 block through an inclusive,
// possibly wrapping nonce range and stops on the first digest strictly
// below the target, on range exhaustion, on a completion timeout or on abort.
module nonce_search_controller #(
    parameter int unsigned NONCE_W        = 32,
    parameter logic [63:0] MSG_LEN        = 64'd447,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [446-NONCE_W:0]     header_prefix,
    input  logic [255:0]             target,
    input  logic [NONCE_W-1:0]       nonce_start,
    input  logic [NONCE_W-1:0]       nonce_end,
    nonce_search_controller_if.master sha,
    output logic                     busy,
    output logic                     found,
    output logic                     exhausted,
    output logic                     timeout_err,
    output logic [NONCE_W-1:0]       result_nonce,
    output logic [255:0]             result_hash,
    output logic [NONCE_W:0]         attempts
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BEGIN,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t               state;
    logic [446-NONCE_W:0] headerReg;
    logic [255:0]         targetReg;
    logic [NONCE_W-1:0]   nonceReg;
    logic [NONCE_W-1:0]   nonceEndReg;
    logic [255:0]         digestReg;
    logic [WCNT_W-1:0]    waitCnt;

    // Message is built straight from the latched header and current nonce;
    // both registers only change on the edge that enters LOAD.
    assign sha.sha_msg    = {headerReg, nonceReg};
    assign sha.sha_length = MSG_LEN;

    // Search sequencer with registered pulses, status flags and results
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state           <= ST_IDLE;
            headerReg       <= '0;
            targetReg       <= '0;
            nonceReg        <= '0;
            nonceEndReg     <= '0;
            digestReg       <= '0;
            waitCnt         <= '0;
            sha.sha_new_msg <= 1'b0;
            sha.sha_begin   <= 1'b0;
            busy            <= 1'b0;
            found           <= 1'b0;
            exhausted       <= 1'b0;
            timeout_err     <= 1'b0;
            result_nonce    <= '0;
            result_hash     <= '0;
            attempts        <= '0;
        end else begin
            sha.sha_new_msg <= 1'b0;
            sha.sha_begin   <= 1'b0;

            if (abort && state != ST_IDLE && state != ST_DONE) begin
                // Abort mid-search: drop to IDLE, clear sticky flags, keep attempts
                state       <= ST_IDLE;
                busy        <= 1'b0;
                found       <= 1'b0;
                exhausted   <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (abort) begin
                            state <= ST_IDLE;
                        end else if (start) begin
                            headerReg       <= header_prefix;
                            targetReg       <= target;
                            nonceReg        <= nonce_start;
                            nonceEndReg     <= nonce_end;
                            found           <= 1'b0;
                            exhausted       <= 1'b0;
                            timeout_err     <= 1'b0;
                            attempts        <= '0;
                            result_nonce    <= '0;
                            result_hash     <= '0;
                            busy            <= 1'b1;
                            sha.sha_new_msg <= 1'b1;
                            state           <= ST_LOAD;
                        end
                    end

                    ST_LOAD: begin
                        sha.sha_begin <= 1'b1;
                        state         <= ST_BEGIN;
                    end

                    ST_BEGIN: begin
                        waitCnt <= '0;
                        state   <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        waitCnt <= waitCnt + 1'b1;
                        if (sha.sha_complete) begin
                            digestReg <= sha.sha_digest;
                            state     <= ST_CHECK;
                        end else if (waitCnt == WAIT_LAST) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ST_DONE;
                        end
                    end

                    ST_CHECK: begin
                        attempts <= attempts + 1'b1;
                        if (digestReg < targetReg) begin
                            found        <= 1'b1;
                            result_nonce <= nonceReg;
                            result_hash  <= digestReg;
                            busy         <= 1'b0;
                            state        <= ST_DONE;
                        end else if (nonceReg == nonceEndReg) begin
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            // Natural wrap through all-ones back to zero
                            nonceReg        <= nonceReg + 1'b1;
                            sha.sha_new_msg <= 1'b1;
                            state           <= ST_LOAD;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
